apb_completer_mem: RTL and testbench

- Parameterised APB completer (slave) with a byte-strobed word memory, programmable wait states and PSLVERR on out-of-range access.
- Sits on the completer side of the APB bus, behind the system's slave-select decode, which uses paddr MSB to pick slave 1 or slave 2.
- Each slave instance in Top becomes one apb_completer_mem.

---
 rtl/apb_pkg.sv | 34 +++
 rtl/apb_byte_mem.sv | 35 +++
 rtl/apb_completer_mem.sv | 115 +++++++++++
 tb/tb_apb_completer_mem.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer memory.
// Holds the FSM state encoding, the slave-select bit position and the byte-strobe merge function.
package apb_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   // The slave-select bit sits this many positions below ADD_WIDTH.
   localparam int SEL_BIT_OFS = 1;

   // strb_merge works on words of up to MAX_WIDTH bits; callers extend and truncate.
   localparam int MAX_WIDTH = 1024;
   localparam int MAX_STRB  = MAX_WIDTH / 8;

   function automatic int sel_bit(input int add_width);
      return add_width - SEL_BIT_OFS;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] strb_merge(
      input logic [MAX_WIDTH-1:0] old_w,
      input logic [MAX_WIDTH-1:0] new_w,
      input logic [MAX_STRB-1:0]  strb
   );
      logic [MAX_WIDTH-1:0] res;
      res = old_w;
      for (int b = 0; b < MAX_STRB; b++) begin
         if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_byte_mem.sv
// Word memory with per-byte write enables, synchronous write and registered read.
// The read register is cleared by reset or by rd_zero; the array itself is never reset.
module apb_byte_mem
   import apb_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MEM_DEPTH = 128,
   parameter int AW        = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [WIDTH/8-1:0] be,
   input  logic               re,
   input  logic               rd_zero,
   input  logic [AW-1:0]      raddr,
   output logic [WIDTH-1:0]   rdata
);

   logic [WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= WIDTH'(strb_merge(MAX_WIDTH'(mem[waddr]), MAX_WIDTH'(wdata),
                                         MAX_STRB'(be)));
   end

   always_ff @(posedge clk) begin
      if (rst || rd_zero) rdata <= '0;
      else if (re)        rdata <= mem[raddr];
   end

endmodule

// File: rtl/apb_completer_mem.sv
// APB completer in front of a byte-strobed word memory, with fixed wait states
// and PSLVERR for word indices beyond the implemented depth.
module apb_completer_mem
   import apb_pkg::*;
#(
   parameter int ADD_WIDTH   = 9,
   parameter int WIDTH       = 32,
   parameter int MEM_DEPTH   = 128,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                 pclk,
   input  logic                 preset,
   input  logic                 psel,
   input  logic                 penable,
   input  logic                 pwrite,
   input  logic [ADD_WIDTH-1:0] paddr,
   input  logic [WIDTH-1:0]     pwdata,
   input  logic [WIDTH/8-1:0]   pstrb,
   output logic [WIDTH-1:0]     prdata,
   output logic                 pready,
   output logic                 pslverr
);

   localparam int         IDX_W     = sel_bit(ADD_WIDTH);
   localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   apb_state_e         state;
   logic [3:0]         cnt;
   logic               wr_q;
   logic               err_q;
   logic [AW-1:0]      idx_q;
   logic [WIDTH-1:0]   wdata_q;
   logic [WIDTH/8-1:0] strb_q;

   logic [IDX_W-1:0]   idx_in;
   logic               err_in;
   logic               setup;
   logic               complete;
   logic               mem_we;
   logic               mem_re;
   logic               mem_rd_zero;

   // The select bit above the index is decoded upstream and not looked at here.
   assign idx_in   = paddr[IDX_W-1:0];
   assign err_in   = int'(idx_in) >= MEM_DEPTH;
   assign setup    = (state == IDLE) && psel && !penable;
   assign complete = (state == ACCESS) && psel && (cnt == 4'd0);

   // Write commits on the completing edge so a following setup reads the new word.
   assign mem_we      = complete && wr_q && !err_q && !preset;
   assign mem_re      = setup && !pwrite && !err_in && !preset;
   assign mem_rd_zero = setup && !pwrite && err_in;

   always_ff @(posedge pclk) begin
      if (preset) begin
         state   <= IDLE;
         cnt     <= '0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (setup) begin
                  state   <= ACCESS;
                  wr_q    <= pwrite;
                  idx_q   <= idx_in[AW-1:0];
                  wdata_q <= pwdata;
                  strb_q  <= pstrb;
                  err_q   <= err_in;
                  cnt     <= WAIT_INIT;
                  pready  <= (WAIT_INIT == 4'd0);
                  pslverr <= (WAIT_INIT == 4'd0) && err_in;
               end
            end
            ACCESS: begin
               // Completion or a dropped psel both end the transfer.
               if (!psel || cnt == 4'd0) begin
                  state   <= IDLE;
                  pready  <= 1'b0;
                  pslverr <= 1'b0;
               end else if (penable) begin
                  cnt     <= cnt - 4'd1;
                  pready  <= (cnt == 4'd1);
                  pslverr <= (cnt == 4'd1) && err_q;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   apb_byte_mem #(
      .WIDTH     (WIDTH),
      .MEM_DEPTH (MEM_DEPTH),
      .AW        (AW)
   ) u_mem (
      .clk     (pclk),
      .rst     (preset),
      .we      (mem_we),
      .waddr   (idx_q),
      .wdata   (wdata_q),
      .be      (strb_q),
      .re      (mem_re),
      .rd_zero (mem_rd_zero),
      .raddr   (idx_in[AW-1:0]),
      .rdata   (prdata)
   );

endmodule

// File: tb/tb_apb_completer_mem.sv
// Directed bench for apb_completer_mem: three instances with 0, 2 and 3 wait states
// share one bus and are picked by their own psel.
module tb_apb_completer_mem;

   logic        pclk = 1'b0;
   logic        preset, preset2;
   logic        psel0, psel2, psel3;
   logic        penable, pwrite;
   logic [8:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata0, prdata2, prdata3;
   logic        pready0, pready2, pready3;
   logic        pslverr0, pslverr2, pslverr3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 pclk = ~pclk;

   apb_completer_mem #(.ADD_WIDTH(9), .WIDTH(32), .MEM_DEPTH(128), .WAIT_CYCLES(0)) u0 (
      .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

   apb_completer_mem #(.ADD_WIDTH(9), .WIDTH(32), .MEM_DEPTH(128), .WAIT_CYCLES(2)) u2 (
      .pclk(pclk), .preset(preset2), .psel(psel2), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata2), .pready(pready2), .pslverr(pslverr2));

   apb_completer_mem #(.ADD_WIDTH(9), .WIDTH(32), .MEM_DEPTH(128), .WAIT_CYCLES(3)) u3 (
      .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

   // One transfer on instance inst; cyc counts setup + access cycles, -1 on timeout.
   // Called and returns 1 time unit after a rising edge.
   task automatic xfer(input int inst, input logic wr, input logic [8:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic er, output int cyc);
      logic rdy;
      rd = 'x;
      er = 1'bx;
      psel0 = (inst == 0); psel2 = (inst == 2); psel3 = (inst == 3);
      penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge pclk); #1;
      penable = 1'b1;
      cyc = 2;
      for (int k = 0; k < 40; k++) begin
         @(negedge pclk);
         case (inst)
            2:       rdy = pready2;
            3:       rdy = pready3;
            default: rdy = pready0;
         endcase
         if (rdy === 1'b1) begin
            case (inst)
               2:       begin rd = prdata2; er = pslverr2; end
               3:       begin rd = prdata3; er = pslverr3; end
               default: begin rd = prdata0; er = pslverr0; end
            endcase
            @(posedge pclk); #1;
            return;
         end
         @(posedge pclk); #1;
         cyc++;
      end
      cyc = -1;
   endtask

   task automatic bus_idle();
      psel0 = 1'b0; psel2 = 1'b0; psel3 = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
   endtask

   task automatic test_reset();
      preset = 1'b1; preset2 = 1'b1;
      psel0 = 1'b0; psel2 = 1'b0; psel3 = 1'b0;
      penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      repeat (3) @(posedge pclk);
      #1; preset = 1'b0; preset2 = 1'b0;
      @(negedge pclk);
      n_cmp++; if (pready0 !== 1'b0) begin n_err++; $display("FAIL reset_pready got %b want 0", pready0); end
      n_cmp++; if (pslverr0 !== 1'b0) begin n_err++; $display("FAIL reset_pslverr got %b want 0", pslverr0); end
      n_cmp++; if (prdata0 !== 32'h0) begin n_err++; $display("FAIL reset_prdata got %h want 00000000", prdata0); end
      @(posedge pclk); #1;
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic er; int cyc;
      xfer(0, 1'b1, 9'h000, 32'hA5A5_1234, 4'b1111, rd, er, cyc);
      n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL wr0_cycles got %0d want 2", cyc); end
      n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL wr0_pslverr got %b want 0", er); end
      xfer(0, 1'b0, 9'h000, 32'h0, 4'b0000, rd, er, cyc);
      n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL rd0_cycles got %0d want 2", cyc); end
      n_cmp++; if (rd !== 32'hA5A5_1234) begin n_err++; $display("FAIL rd0_data got %h want a5a51234", rd); end
      n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL rd0_pslverr got %b want 0", er); end
      bus_idle();
   endtask

   task automatic test_strobe();
      logic [31:0] rd; logic er; int cyc;
      xfer(0, 1'b1, 9'h003, 32'h0000_0003, 4'b1111, rd, er, cyc);
      xfer(0, 1'b1, 9'h003, 32'hFFFF_FFFF, 4'b0101, rd, er, cyc);
      xfer(0, 1'b0, 9'h003, 32'h0, 4'b1111, rd, er, cyc);
      n_cmp++; if (rd !== 32'h00FF_00FF) begin n_err++; $display("FAIL strb_merge got %h want 00ff00ff", rd); end
      xfer(0, 1'b1, 9'h003, 32'h1234_5678, 4'b0000, rd, er, cyc);
      n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL strb0_pslverr got %b want 0", er); end
      n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL strb0_cycles got %0d want 2", cyc); end
      xfer(0, 1'b0, 9'h003, 32'h0, 4'b0000, rd, er, cyc);
      n_cmp++; if (rd !== 32'h00FF_00FF) begin n_err++; $display("FAIL strb0_data got %h want 00ff00ff", rd); end
      bus_idle();
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; logic er; int cyc;
      xfer(3, 1'b1, 9'h005, 32'h5555_AAAA, 4'b1111, rd, er, cyc);
      n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL wait_wr_cycles got %0d want 5", cyc); end
      xfer(3, 1'b0, 9'h005, 32'h0, 4'b0000, rd, er, cyc);
      n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL wait_rd_cycles got %0d want 5", cyc); end
      n_cmp++; if (rd !== 32'h5555_AAAA) begin n_err++; $display("FAIL wait_rd_data got %h want 5555aaaa", rd); end
      n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL wait_rd_pslverr got %b want 0", er); end
      bus_idle();
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd; logic er; int cyc;
      xfer(0, 1'b1, 9'h048, 32'h1122_3344, 4'b1111, rd, er, cyc);
      xfer(0, 1'b1, 9'h0C8, 32'hDEAD_BEEF, 4'b1111, rd, er, cyc);
      n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL oor_wr_pslverr got %b want 1", er); end
      xfer(0, 1'b0, 9'h0C8, 32'h0, 4'b0000, rd, er, cyc);
      n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL oor_rd_pslverr got %b want 1", er); end
      n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL oor_rd_data got %h want 00000000", rd); end
      xfer(0, 1'b0, 9'h048, 32'h0, 4'b0000, rd, er, cyc);
      n_cmp++; if (rd !== 32'h1122_3344) begin n_err++; $display("FAIL oor_alias_data got %h want 11223344", rd); end
      n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL oor_alias_pslverr got %b want 0", er); end
      bus_idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int cyc;
      for (int i = 0; i < 14; i++) begin
         xfer(0, 1'b1, 9'(i), 32'(i), 4'b1111, rd, er, cyc);
         n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL b2b_wr_cycles idx %0d got %0d want 2", i, cyc); end
      end
      for (int i = 0; i < 14; i++) begin
         xfer(0, 1'b0, 9'(i), 32'h0, 4'b0000, rd, er, cyc);
         n_cmp++; if (rd !== 32'(i)) begin n_err++; $display("FAIL b2b_rd_data idx %0d got %h want %h", i, rd, 32'(i)); end
         n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL b2b_rd_cycles idx %0d got %0d want 2", i, cyc); end
      end
      bus_idle();
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] rd; logic er; int cyc;
      xfer(2, 1'b1, 9'h007, 32'h7777_0007, 4'b1111, rd, er, cyc);
      n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL rst_pre_cycles got %0d want 4", cyc); end
      xfer(2, 1'b0, 9'h007, 32'h0, 4'b0000, rd, er, cyc);
      n_cmp++; if (rd !== 32'h7777_0007) begin n_err++; $display("FAIL rst_pre_data got %h want 77770007", rd); end
      // Start a write, then reset while it is still waiting.
      psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h007;
      pwdata = 32'hBAD0_BAD0; pstrb = 4'b1111;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      n_cmp++; if (pready2 !== 1'b0) begin n_err++; $display("FAIL rst_wait_pready got %b want 0", pready2); end
      @(posedge pclk); #1;
      preset2 = 1'b1;
      @(posedge pclk); #1;
      preset2 = 1'b0;
      psel2 = 1'b0; penable = 1'b0;
      @(negedge pclk);
      n_cmp++; if (pready2 !== 1'b0) begin n_err++; $display("FAIL rst_mid_pready got %b want 0", pready2); end
      n_cmp++; if (pslverr2 !== 1'b0) begin n_err++; $display("FAIL rst_mid_pslverr got %b want 0", pslverr2); end
      n_cmp++; if (prdata2 !== 32'h0) begin n_err++; $display("FAIL rst_mid_prdata got %h want 00000000", prdata2); end
      @(posedge pclk); #1;
      xfer(2, 1'b0, 9'h007, 32'h0, 4'b0000, rd, er, cyc);
      n_cmp++; if (rd !== 32'h7777_0007) begin n_err++; $display("FAIL rst_post_data got %h want 77770007", rd); end
      bus_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_strobe();
      test_wait_states();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
